canv_layer_mix: RTL and testbench
=================================

Name: canv_layer_mix

Overview:
- Display-side canvas pixel pipeline for clk_pix: extracts colour indices from vram words for up to LAYERS canvases, each with runtime-selectable bits per pixel.
- Applies per-layer transparency and fixed priority, and drives one shared CLUT address and paint flag.
- Sits between the canvas display AGUs/vram read ports and the CLUT.
- Successor to the fixed single-canvas pixel select: bpp is a register, not a parameter, and layers are composited.

Parameters:
- LAYERS, 2, number of canvas layers (1-4); layer 0 is highest priority.
- WORD, 32, vram word width (bits); power of two, at least 8.
- CIDXW, 8, colour index width (bits), equal to the CLUT address width.
- VRAM_LAT, 2, cycles from AGU address/pix_id output to vram_dout valid (1-4).
- PIX_IDW, 5, pixel ID width, equal to $clog2(WORD).
- LIDW, 2, layer ID width, at least max(1, $clog2(LAYERS)).

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at frame start; active config loads here.
- cfg_we  in  1  write shadow config of layer cfg_layer.
- cfg_layer  in  LIDW  layer selected for config write.
- cfg_en  in  1  layer enable.
- cfg_bpp  in  2  bpp code: 0=1, 1=2, 2=4, 3=8.
- cfg_trans_en  in  1  transparency enable.
- cfg_trans_idx  in  CIDXW  transparent colour index.
- pix_id  in  LAYERS*PIX_IDW  per-layer pixel ID within word, aligned with AGU address.
- paint_in  in  LAYERS  per-layer AGU paint, aligned with AGU address.
- vram_dout  in  LAYERS*WORD  per-layer vram read data, valid VRAM_LAT cycles after address.
- clut_addr  out  CIDXW  colour index for CLUT.
- paint  out  1  a visible layer pixel is present.
- layer_id  out  LIDW  layer supplying clut_addr.

Behaviour:
- Config registers:
  - Each layer has a shadow register set and an active register set: {en, bpp, trans_en, trans_idx}.
  - cfg_we writes the shadow set of cfg_layer on the same edge. If cfg_layer >= LAYERS, the write is ignored.
  - On a frame_start cycle, active <= shadow for all layers. A cfg_we in that same cycle is merged, so the written value reaches active immediately.
  - A cfg_we outside frame_start never changes active mid-frame.
- Reset values:
  - Shadow and active, layer 0: en=1, bpp=2 (4 bpp), trans_en=0, trans_idx=0.
  - Shadow and active, other layers: all zero.
  - Outputs: clut_addr=0, paint=0, layer_id=0; all delay-line stages cleared.
- Alignment:
  - pix_id and paint_in are delayed by exactly VRAM_LAT registers per layer so they align with vram_dout.
- Extraction, per layer, using the active bpp:
  - n = 1 << bpp_code; ppw = WORD/n.
  - id = delayed pix_id mod ppw (upper bits ignored).
  - idx = (vram_dout >> (id*n)) & ((1<<n)-1), zero-extended to CIDXW.
  - For 8 bpp with CIDXW < 8, idx is truncated to CIDXW.
- Visibility:
  - A layer is visible when en & delayed paint_in & !(trans_en & idx==trans_idx).
- Priority:
  - The lowest-numbered visible layer wins.
  - With no visible layer: paint=0, clut_addr=0, layer_id=0.
- Output stage:
  - Registered once. Total latency from AGU pix_id/paint_in to outputs is VRAM_LAT+1 cycles.
  - Throughput is one pixel per cycle; there is no stall or handshake.
- Reset mid-frame:
  - Pipeline contents are discarded. Outputs are 0 on the cycle after rst_pix asserts and stay 0 until valid data propagates.
- Boundary cases:
  - frame_start does not flush the pipeline: pixels in flight complete using the active config in force at each stage's register, which changes on the load edge.
  - With trans_en=1 and trans_idx=0, index 0 is transparent; an all-zero word passes the next layer through.

Test Plan:
1. Reset, VRAM_LAT=2, layer 0 at 4 bpp, vram_dout[0]=32'h7654_3210, pix_id 0..7 on consecutive cycles with paint_in=1 -> clut_addr 0,1,..,7 starting 3 cycles later, paint=1, layer_id=0.
2. cfg_we layer 0 bpp=3 mid-frame, word 32'hAABB_CCDD, pix_id=1 -> clut_addr stays 4-bit extraction (8'h0D>>... i.e. 8'h0D for id 1 at 4 bpp) until the next frame_start; afterwards pix_id=1 gives 8'hCC and pix_id=5 gives 8'hCC (mod 4).
3. Two layers: layer 0 with trans_en=1, trans_idx=0, word 0; layer 1 enabled at 2 bpp, word 32'h0000_00E4 -> pix_id 0..3 give clut_addr 0,1,2,3 with layer_id=1; change the layer 0 word to 32'h0000_0005 (pix_id 0) -> clut_addr=5, layer_id=0.
4. All layers disabled or paint_in=0 -> paint=0, clut_addr=0, layer_id=0 for every cycle.
5. cfg_we coincident with frame_start (layer 1 en=1) -> layer 1 affects the pixel entering extraction on the next cycle; cfg_layer=3 with LAYERS=2 -> no register changes.
6. rst_pix asserted for one cycle during a streaming frame -> outputs 0 on the next cycle; config returns to reset values; the first valid output appears VRAM_LAT+1 cycles after paint_in resumes.

Source files
------------

// File: rtl/canv_layer_mix.sv
// Canvas layer compositor: per-layer vram pixel extraction with runtime bpp,
// transparency and fixed priority, driving a single CLUT address.
module canv_layer_mix #(
  parameter int unsigned LAYERS   = 2,
  parameter int unsigned WORD     = 32,
  parameter int unsigned CIDXW    = 8,
  parameter int unsigned VRAM_LAT = 2,
  parameter int unsigned PIX_IDW  = 5,
  parameter int unsigned LIDW     = 2
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic                        frame_start,
  input  logic                        cfg_we,
  input  logic [LIDW-1:0]             cfg_layer,
  input  logic                        cfg_en,
  input  logic [1:0]                  cfg_bpp,
  input  logic                        cfg_trans_en,
  input  logic [CIDXW-1:0]            cfg_trans_idx,
  input  logic [LAYERS*PIX_IDW-1:0]   pix_id,
  input  logic [LAYERS-1:0]           paint_in,
  input  logic [LAYERS*WORD-1:0]      vram_dout,
  output logic [CIDXW-1:0]            clut_addr,
  output logic                        paint,
  output logic [LIDW-1:0]             layer_id
);

  typedef struct packed {
    logic             en;
    logic [1:0]       bpp;
    logic             trans_en;
    logic [CIDXW-1:0] trans_idx;
  } cfg_t;

  cfg_t shadow_q [LAYERS];
  cfg_t shadow_d [LAYERS];
  cfg_t active_q [LAYERS];
  cfg_t active_d [LAYERS];

  logic [LAYERS*PIX_IDW-1:0] pid_q [VRAM_LAT];
  logic [LAYERS-1:0]         pnt_q [VRAM_LAT];

  logic [CIDXW-1:0]  idx [LAYERS];
  logic [LAYERS-1:0] vis;

  logic [CIDXW-1:0] clut_addr_q, clut_addr_d;
  logic             paint_q, paint_d;
  logic [LIDW-1:0]  layer_id_q, layer_id_d;

  function automatic cfg_t cfg_rst(input int unsigned l);
    cfg_t c;
    c = '0;
    if (l == 0) begin
      c.en  = 1'b1;
      c.bpp = 2'd2;
    end
    return c;
  endfunction

  // A write in a frame_start cycle lands in shadow first, so the load sees it.
  always_comb begin
    cfg_t wr;
    wr = '{en: cfg_en, bpp: cfg_bpp, trans_en: cfg_trans_en, trans_idx: cfg_trans_idx};
    for (int unsigned l = 0; l < LAYERS; l++) begin
      shadow_d[l] = shadow_q[l];
      if (cfg_we && (cfg_layer == LIDW'(l))) shadow_d[l] = wr;
      active_d[l] = frame_start ? shadow_d[l] : active_q[l];
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LAYERS; l++) begin
      int unsigned      sh;
      logic [7:0]       raw;
      logic [7:0]       nmask;
      logic [PIX_IDW-1:0] pid;
      pid = pid_q[VRAM_LAT-1][l*PIX_IDW +: PIX_IDW];
      sh  = (32'(pid) & ((WORD >> active_q[l].bpp) - 1)) << active_q[l].bpp;
      raw = 8'(vram_dout[l*WORD +: WORD] >> sh);
      case (active_q[l].bpp)
        2'd0:    nmask = 8'h01;
        2'd1:    nmask = 8'h03;
        2'd2:    nmask = 8'h0F;
        default: nmask = 8'hFF;
      endcase
      idx[l] = CIDXW'(raw & nmask);
      vis[l] = active_q[l].en & pnt_q[VRAM_LAT-1][l] &
               ~(active_q[l].trans_en & (idx[l] == active_q[l].trans_idx));
    end
  end

  // First visible layer in ascending order wins; paint_d doubles as the found flag.
  always_comb begin
    clut_addr_d = '0;
    paint_d     = 1'b0;
    layer_id_d  = '0;
    for (int unsigned l = 0; l < LAYERS; l++) begin
      if (vis[l] && !paint_d) begin
        clut_addr_d = idx[l];
        paint_d     = 1'b1;
        layer_id_d  = LIDW'(l);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int unsigned l = 0; l < LAYERS; l++) begin
        shadow_q[l] <= cfg_rst(l);
        active_q[l] <= cfg_rst(l);
      end
      for (int unsigned s = 0; s < VRAM_LAT; s++) begin
        pid_q[s] <= '0;
        pnt_q[s] <= '0;
      end
      clut_addr_q <= '0;
      paint_q     <= 1'b0;
      layer_id_q  <= '0;
    end else begin
      for (int unsigned l = 0; l < LAYERS; l++) begin
        shadow_q[l] <= shadow_d[l];
        active_q[l] <= active_d[l];
      end
      pid_q[0] <= pix_id;
      pnt_q[0] <= paint_in;
      for (int unsigned s = 1; s < VRAM_LAT; s++) begin
        pid_q[s] <= pid_q[s-1];
        pnt_q[s] <= pnt_q[s-1];
      end
      clut_addr_q <= clut_addr_d;
      paint_q     <= paint_d;
      layer_id_q  <= layer_id_d;
    end
  end

  assign clut_addr = clut_addr_q;
  assign paint     = paint_q;
  assign layer_id  = layer_id_q;

endmodule

// File: tb/tb_canv_layer_mix.sv
// Scoreboard bench for canv_layer_mix (LAYERS=2, WORD=32, VRAM_LAT=2):
// reference model plus hand-derived expected outputs per scenario.
module tb_canv_layer_mix;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic        frame_start;
  logic        cfg_we;
  logic [1:0]  cfg_layer;
  logic        cfg_en;
  logic [1:0]  cfg_bpp;
  logic        cfg_trans_en;
  logic [7:0]  cfg_trans_idx;
  logic [9:0]  pix_id;
  logic [1:0]  paint_in;
  logic [63:0] vram_dout;
  logic [7:0]  clut_addr;
  logic        paint;
  logic [1:0]  layer_id;

  canv_layer_mix #(
    .LAYERS(2), .WORD(32), .CIDXW(8), .VRAM_LAT(2), .PIX_IDW(5), .LIDW(2)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_en(cfg_en), .cfg_bpp(cfg_bpp),
    .cfg_trans_en(cfg_trans_en), .cfg_trans_idx(cfg_trans_idx),
    .pix_id(pix_id), .paint_in(paint_in), .vram_dout(vram_dout),
    .clut_addr(clut_addr), .paint(paint), .layer_id(layer_id)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [9:0]  pid;
    logic [1:0]  pnt;
    logic [63:0] w;
  } rec_t;

  typedef struct packed {
    logic       en;
    logic [1:0] bpp;
    logic       te;
    logic [7:0] ti;
  } mcfg_t;

  rec_t        pipe[$];
  logic [10:0] sb[$];
  mcfg_t       sh [2];
  mcfg_t       act[2];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [10:0] model(input rec_t r);
    logic [10:0] o;
    logic [7:0]  ix;
    logic [4:0]  p;
    logic [31:0] w;
    int          n, id;
    o = '0;
    for (int L = 1; L >= 0; L--) begin
      n  = 1 << act[L].bpp;
      p  = r.pid[L*5 +: 5];
      w  = r.w[L*32 +: 32];
      id = int'(p) % (32 / n);
      ix = '0;
      for (int b = 0; b < n; b++) ix[b] = w[id*n + b];
      if (act[L].en && r.pnt[L] && !(act[L].te && ix == act[L].ti))
        o = {ix, 1'b1, 2'(L)};
    end
    return o;
  endfunction

  task automatic set_cfg(input logic [1:0] l, input logic en, input logic [1:0] bpp,
                         input logic te, input logic [7:0] ti);
    cfg_we = 1'b1; cfg_layer = l; cfg_en = en; cfg_bpp = bpp;
    cfg_trans_en = te; cfg_trans_idx = ti;
  endtask

  // One pixel clock: drive, advance model, pop expected, sample DUT after the edge.
  task automatic cyc(input logic fs, input logic rs, input logic [9:0] pid,
                     input logic [1:0] pnt, input logic [63:0] w,
                     output logic [10:0] got, output logic [10:0] exp);
    rec_t  r, e;
    mcfg_t wr;
    r.pid = pid; r.pnt = pnt; r.w = w;
    pipe.push_back(r);
    e = pipe.pop_front();
    frame_start = fs; rst_pix = rs; pix_id = pid; paint_in = pnt; vram_dout = e.w;
    if (rs) begin
      sb.push_back(11'h0);
      sh[0] = '{en: 1'b1, bpp: 2'd2, te: 1'b0, ti: 8'h00};
      sh[1] = '0;
      act = sh;
      pipe.delete();
      repeat (2) pipe.push_back('0);
    end else begin
      sb.push_back(model(e));
      wr = '{en: cfg_en, bpp: cfg_bpp, te: cfg_trans_en, ti: cfg_trans_idx};
      for (int i = 0; i < 2; i++) if (cfg_we && cfg_layer == 2'(i)) sh[i] = wr;
      if (fs) act = sh;
    end
    @(posedge clk_pix);
    @(negedge clk_pix);
    cfg_we = 1'b0; frame_start = 1'b0; rst_pix = 1'b0;
    got = {clut_addr, paint, layer_id};
    exp = sb.pop_front();
  endtask

  task automatic test_reset();
    logic [10:0] g, e;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 10'h3FF, 2'b11, {2{32'hFFFF_FFFF}}, g, e);
      checks++;
      if (g !== 11'h0 || e !== 11'h0) begin
        errors++;
        $display("FAIL reset[%0d] got=%h want=000", i, g);
      end
    end
  endtask

  task automatic test_basic();
    logic [10:0] g, e, c;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, {5'd0, 5'(i % 8)}, {1'b0, i < 8}, {32'h0, 32'h7654_3210}, g, e);
      c = (i >= 2) ? {8'(i - 2), 1'b1, 2'd0} : 11'h0;
      checks++;
      if (g !== e || g !== c) begin
        errors++;
        $display("FAIL basic[%0d] got=%h model=%h want=%h", i, g, e, c);
      end
    end
  endtask

  task automatic test_bpp_switch();
    logic [10:0] g, e, c;
    logic [9:0]  p;
    logic [1:0]  pn;
    set_cfg(2'd0, 1'b1, 2'd3, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      p  = (i == 6) ? 10'd5 : 10'd1;
      pn = (i == 1 || i == 5 || i == 6) ? 2'b01 : 2'b00;
      cyc(i == 4, 1'b0, p, pn, {32'h0, 32'hAABB_CCDD}, g, e);
      c = (i == 3) ? {8'h0D, 1'b1, 2'd0} : (i == 7 || i == 8) ? {8'hCC, 1'b1, 2'd0} : 11'h0;
      checks++;
      if (g !== e || g !== c) begin
        errors++;
        $display("FAIL bpp_switch[%0d] got=%h model=%h want=%h", i, g, e, c);
      end
    end
  endtask

  task automatic test_transparency();
    logic [10:0] g, e, c;
    logic [63:0] w;
    set_cfg(2'd0, 1'b1, 2'd2, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, g, e);
    set_cfg(2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, '0, 2'b00, '0, g, e);
    for (int i = 0; i < 7; i++) begin
      w = (i == 4) ? {32'hE4, 32'h5} : {32'hE4, 32'h0};
      cyc(1'b0, 1'b0, (i < 4) ? {5'(i), 5'(i)} : 10'd0, (i < 5) ? 2'b11 : 2'b00, w, g, e);
      c = (i >= 2 && i <= 5) ? {8'(i - 2), 1'b1, 2'd1} : (i == 6) ? {8'h05, 1'b1, 2'd0} : 11'h0;
      checks++;
      if (g !== e || g !== c) begin
        errors++;
        $display("FAIL transparency[%0d] got=%h model=%h want=%h", i, g, e, c);
      end
    end
  endtask

  task automatic test_no_paint();
    logic [10:0] g, e;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)  set_cfg(2'd0, 1'b0, 2'd2, 1'b0, 8'h00);
      if (i == 1)  set_cfg(2'd1, 1'b0, 2'd1, 1'b0, 8'h00);
      if (i == 10) set_cfg(2'd0, 1'b1, 2'd2, 1'b0, 8'h00);
      if (i == 11) set_cfg(2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
      cyc(i == 1 || i == 11, 1'b0, 10'($urandom), (i < 10) ? 2'b11 : 2'b00,
          {$urandom, $urandom}, g, e);
      checks++;
      if (g !== e || g !== 11'h0) begin
        errors++;
        $display("FAIL no_paint[%0d] got=%h model=%h want=000", i, g, e);
      end
    end
  endtask

  task automatic test_cfg_merge();
    logic [10:0] g, e, c;
    set_cfg(2'd0, 1'b0, 2'd2, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, '0, 2'b00, '0, g, e);
    set_cfg(2'd1, 1'b0, 2'd1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, '0, 2'b00, '0, g, e);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) set_cfg(2'd1, 1'b1, 2'd1, 1'b0, 8'h00);
      if (i == 7) set_cfg(2'd3, 1'b0, 2'd0, 1'b1, 8'hFF);
      cyc(i == 5 || i == 7, 1'b0, {5'd1, 5'd0}, (i < 10) ? 2'b10 : 2'b00,
          {32'hE4, 32'h0}, g, e);
      c = (i >= 6) ? {8'h01, 1'b1, 2'd1} : 11'h0;
      checks++;
      if (g !== e || g !== c) begin
        errors++;
        $display("FAIL cfg_merge[%0d] got=%h model=%h want=%h", i, g, e, c);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] g, e, c;
    set_cfg(2'd0, 1'b1, 2'd3, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, '0, 2'b00, '0, g, e);
    cyc(1'b0, 1'b0, '0, 2'b00, '0, g, e);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, i == 5, {5'd0, 5'(i % 8)}, 2'b01, {32'h0, 32'h7654_3210}, g, e);
      case (i)
        2: c = {8'h10, 1'b1, 2'd0};
        3: c = {8'h32, 1'b1, 2'd0};
        4: c = {8'h54, 1'b1, 2'd0};
        8: c = {8'h06, 1'b1, 2'd0};
        9: c = {8'h07, 1'b1, 2'd0};
        default: c = 11'h0;
      endcase
      checks++;
      if (g !== e || g !== c) begin
        errors++;
        $display("FAIL mid_reset[%0d] got=%h model=%h want=%h", i, g, e, c);
      end
    end
  endtask

  initial begin
    rst_pix = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_layer = '0;
    cfg_en = 1'b0; cfg_bpp = '0; cfg_trans_en = 1'b0; cfg_trans_idx = '0;
    pix_id = '0; paint_in = '0; vram_dout = '0;
    repeat (2) pipe.push_back('0);
    @(negedge clk_pix);
    test_reset();
    test_basic();
    test_bpp_switch();
    test_transparency();
    test_no_paint();
    test_cfg_merge();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
